// File: rtl/register_bank_pkg.sv
// Shared types and helpers for the register bank: FSM state encoding and a
// constant-evaluable ceiling-log2 used to size address ports.
package register_bank_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/register_bank_rdport.sv
// One registered read port: address mux over the bank, write-first forwarding
// of a same-edge write, and the output data/valid registers.
module register_bank_rdport
  import register_bank_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              i_reset,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  input  logic              i_wr_fire,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]  i_wr_data,
  input  logic [WIDTH-1:0]  i_mem [DEPTH],
  output logic [WIDTH-1:0]  o_rd_data,
  output logic              o_rd_valid
);

  logic [WIDTH-1:0] w_rd_word;

  // A write landing on the same edge wins over the stale array contents.
  always_comb begin
    w_rd_word = i_mem[i_rd_addr];
    if (i_wr_fire && (i_wr_addr == i_rd_addr)) begin
      w_rd_word = i_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!i_reset) begin
      o_rd_data  <= '0;
      o_rd_valid <= 1'b0;
    end else begin
      o_rd_valid <= i_rd_en;
      if (i_rd_en) begin
        o_rd_data <= w_rd_word;
      end
    end
  end

endmodule

// File: rtl/register_bank.sv
// Register bank with one write port, two registered read ports and a
// DEPTH-cycle clearing sweep that runs after reset or on clear_req.
module register_bank
  import register_bank_pkg::*;
#(
  parameter  int WIDTH  = 8,
  parameter  int DEPTH  = 4,
  localparam int ADDR_W = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              clear_req,
  input  logic              rd_en_a,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [WIDTH-1:0]  rd_data_a,
  output logic              rd_valid_a,
  input  logic              rd_en_b,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [WIDTH-1:0]  rd_data_b,
  output logic              rd_valid_b,
  output logic              busy
);

  state_t            r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic [WIDTH-1:0]  r_mem [DEPTH];

  logic w_idle;
  logic w_wr_fire;
  logic w_rd_en_a;
  logic w_rd_en_b;

  assign w_idle    = (r_state == IDLE);
  assign busy      = (r_state == CLEAR);
  assign wr_ready  = w_idle;
  assign w_wr_fire = wr_valid && w_idle;
  assign w_rd_en_a = rd_en_a && w_idle;
  assign w_rd_en_b = rd_en_b && w_idle;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= CLEAR;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        CLEAR: begin
          if (r_cnt == ADDR_W'(DEPTH - 1)) begin
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + ADDR_W'(1);
          end
        end
        IDLE: begin
          if (clear_req) begin
            r_state <= CLEAR;
            r_cnt   <= '0;
          end
        end
        default: r_state <= CLEAR;
      endcase
    end
  end

  // Contents have no reset; the sweep that follows reset zeroes them.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (r_state == CLEAR) begin
        r_mem[r_cnt] <= '0;
      end else if (w_wr_fire) begin
        r_mem[wr_addr] <= wr_data;
      end
    end
  end

  register_bank_rdport #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_rdport_a (
    .clk        (clk),
    .i_reset    (reset),
    .i_rd_en    (w_rd_en_a),
    .i_rd_addr  (rd_addr_a),
    .i_wr_fire  (w_wr_fire),
    .i_wr_addr  (wr_addr),
    .i_wr_data  (wr_data),
    .i_mem      (r_mem),
    .o_rd_data  (rd_data_a),
    .o_rd_valid (rd_valid_a)
  );

  register_bank_rdport #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_rdport_b (
    .clk        (clk),
    .i_reset    (reset),
    .i_rd_en    (w_rd_en_b),
    .i_rd_addr  (rd_addr_b),
    .i_wr_fire  (w_wr_fire),
    .i_wr_addr  (wr_addr),
    .i_wr_data  (wr_data),
    .i_mem      (r_mem),
    .o_rd_data  (rd_data_b),
    .o_rd_valid (rd_valid_b)
  );

endmodule

// File: tb/tb_register_bank.sv
// Bench for register_bank (WIDTH=8, DEPTH=4): directed scenarios followed by
// random traffic, all checked against a cycle-level behavioural model.
module tb_register_bank;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             wr_valid;
  logic             wr_ready;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             clear_req;
  logic             rd_en_a, rd_en_b;
  logic [AW-1:0]    rd_addr_a, rd_addr_b;
  logic [WIDTH-1:0] rd_data_a, rd_data_b;
  logic             rd_valid_a, rd_valid_b;
  logic             busy;

  int checks = 0;
  int errors = 0;

  // Model state: array contents, remaining sweep cycles, expected read outputs.
  logic [WIDTH-1:0] m_mem [DEPTH];
  int               m_sweep_left;
  logic [WIDTH-1:0] m_da, m_db;
  logic             m_va, m_vb;

  register_bank #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .clear_req  (clear_req),
    .rd_en_a    (rd_en_a),
    .rd_addr_a  (rd_addr_a),
    .rd_data_a  (rd_data_a),
    .rd_valid_a (rd_valid_a),
    .rd_en_b    (rd_en_b),
    .rd_addr_b  (rd_addr_b),
    .rd_data_b  (rd_data_b),
    .rd_valid_b (rd_valid_b),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one edge using the inputs currently applied.
  task automatic model_edge();
    if (!reset) begin
      m_sweep_left = DEPTH;
      m_da = '0; m_db = '0; m_va = 1'b0; m_vb = 1'b0;
    end else if (m_sweep_left > 0) begin
      m_mem[DEPTH - m_sweep_left] = '0;
      m_sweep_left--;
      m_va = 1'b0;
      m_vb = 1'b0;
    end else begin
      if (wr_valid) m_mem[wr_addr] = wr_data;
      m_va = rd_en_a;
      m_vb = rd_en_b;
      if (rd_en_a) m_da = m_mem[rd_addr_a];
      if (rd_en_b) m_db = m_mem[rd_addr_b];
      if (clear_req) m_sweep_left = DEPTH;
    end
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check({tag, ".busy"},     32'(busy),       32'(m_sweep_left > 0));
    check({tag, ".wr_ready"}, 32'(wr_ready),   32'(m_sweep_left == 0));
    check({tag, ".valid_a"},  32'(rd_valid_a), 32'(m_va));
    check({tag, ".valid_b"},  32'(rd_valid_b), 32'(m_vb));
    check({tag, ".data_a"},   32'(rd_data_a),  32'(m_da));
    check({tag, ".data_b"},   32'(rd_data_b),  32'(m_db));
  endtask

  task automatic idle_inputs();
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0; clear_req = 1'b0;
    rd_en_a = 1'b0; rd_addr_a = '0; rd_en_b = 1'b0; rd_addr_b = '0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_sweep_left = DEPTH;
    m_da = '0; m_db = '0; m_va = 1'b0; m_vb = 1'b0;
    idle_inputs();
    reset = 1'b0;

    // Reset state
    step("reset0");
    step("reset1");
    reset = 1'b1;

    // Sweep after reset release, then all locations read back zero
    for (int i = 0; i < DEPTH; i++) step("post_reset_sweep");
    for (int a = 0; a < DEPTH; a++) begin
      rd_en_a = 1'b1; rd_addr_a = AW'(a);
      rd_en_b = 1'b1; rd_addr_b = AW'(DEPTH - 1 - a);
      step("read_zero");
      check("read_zero.explicit", 32'(rd_data_a), 32'h00);
    end
    idle_inputs();
    step("gap");
    check("valid_pulse_drops", 32'(rd_valid_a), 32'h0);

    // Write then dual-port read of the same address
    wr_valid = 1'b1; wr_addr = 2'd2; wr_data = 8'hA5;
    step("wr_a5");
    idle_inputs();
    rd_en_a = 1'b1; rd_addr_a = 2'd2; rd_en_b = 1'b1; rd_addr_b = 2'd2;
    step("dual_rd_a5");
    check("dual_rd.a", 32'(rd_data_a), 32'hA5);
    check("dual_rd.b", 32'(rd_data_b), 32'hA5);

    // Same-edge write with forwarding on port A, port B reads elsewhere
    idle_inputs();
    wr_valid = 1'b1; wr_addr = 2'd1; wr_data = 8'h3C;
    rd_en_a = 1'b1; rd_addr_a = 2'd1; rd_en_b = 1'b1; rd_addr_b = 2'd2;
    step("fwd_3c");
    check("fwd.a", 32'(rd_data_a), 32'h3C);

    // Hold: no read keeps previous data
    idle_inputs();
    step("hold");
    check("hold.a", 32'(rd_data_a), 32'h3C);

    // Fill, clear, writes and clear_req during sweep ignored
    for (int a = 0; a < DEPTH; a++) begin
      wr_valid = 1'b1; wr_addr = AW'(a); wr_data = 8'(8'h11 * (a + 1));
      step("fill");
    end
    idle_inputs();
    clear_req = 1'b1;
    step("clear_enter");
    clear_req = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      wr_valid = 1'b1; wr_addr = AW'(i); wr_data = 8'hFF;
      clear_req = (i == 1);
      step("sweep_wr_ignored");
    end
    idle_inputs();
    for (int a = 0; a < DEPTH; a++) begin
      rd_en_a = 1'b1; rd_addr_a = AW'(a);
      rd_en_b = 1'b1; rd_addr_b = AW'(a);
      step("after_clear");
      check("after_clear.explicit", 32'(rd_data_b), 32'h00);
    end

    // Reset in sweep cycle 2 restarts the sweep
    idle_inputs();
    wr_valid = 1'b1; wr_addr = 2'd3; wr_data = 8'h5A;
    step("pre_restart_wr");
    idle_inputs();
    clear_req = 1'b1;
    step("restart_clear");
    clear_req = 1'b0;
    step("restart_cnt0");
    step("restart_cnt1");
    reset = 1'b0;
    step("restart_reset");
    reset = 1'b1;
    for (int i = 0; i < DEPTH; i++) step("restart_sweep");
    check("restart_idle", 32'(busy), 32'h0);

    // Read dropped during sweep, data holds
    wr_valid = 1'b1; wr_addr = 2'd3; wr_data = 8'h77;
    step("wr_77");
    idle_inputs();
    rd_en_a = 1'b1; rd_addr_a = 2'd3;
    clear_req = 1'b1;
    step("rd_77_and_clear");
    clear_req = 1'b0;
    rd_addr_a = 2'd0;
    step("rd_in_clear");
    check("rd_in_clear.valid", 32'(rd_valid_a), 32'h0);
    check("rd_in_clear.hold", 32'(rd_data_a), 32'h77);
    for (int i = 1; i < DEPTH; i++) step("rd_in_clear_rest");
    idle_inputs();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      reset     = ($urandom_range(0, 59) != 0);
      clear_req = ($urandom_range(0, 19) == 0);
      wr_valid  = $urandom_range(0, 1) == 1;
      wr_addr   = AW'($urandom_range(0, DEPTH - 1));
      wr_data   = WIDTH'($urandom);
      rd_en_a   = $urandom_range(0, 2) != 0;
      rd_addr_a = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom_range(0, DEPTH - 1));
      rd_en_b   = $urandom_range(0, 2) != 0;
      rd_addr_b = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom_range(0, DEPTH - 1));
      step("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
